// File: rtl/npu_mmio_pkg.sv
// rtl/npu_mmio_pkg.sv - shared MMIO opcodes, done_vec bit map and f2h FSM state type
// Timestamp FSM states and the 64-bit entry width exist only when F2H_TIMESTAMP_EN is defined.
package npu_mmio_pkg;

  localparam logic [7:0] DEFAULT_ACK_OPCODE = 8'hA5;
  localparam logic [7:0] DEFAULT_CLR_OPCODE = 8'h5A;

  localparam int EXEC_LSB  = 0;
  localparam int EXEC_MSB  = 27;
  localparam int FETCH_BIT = 28;
  localparam int CU_BIT    = 29;
  localparam int LDST_BIT  = 30;
  localparam int MOVE_BIT  = 31;

`ifdef F2H_TIMESTAMP_EN
  localparam int ENTRY_W = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_SEND_TS,
    ST_WAIT_TS_ACK
  } f2h_state_e;
`else
  localparam int ENTRY_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK
  } f2h_state_e;
`endif

  function automatic logic is_cmd(input logic [31:0] word, input logic [7:0] opcode);
    return word[31:24] == opcode;
  endfunction

endpackage

// File: rtl/f2h_event_tx_if.sv
// rtl/f2h_event_tx_if.sv - host MMIO word/strobe pairs in both directions
// master = host side, slave = fabric side (f2h_event_tx).
interface f2h_event_tx_if;

  logic [31:0] h2f_pio32;
  logic        h2f_write;
  logic [31:0] f2h_pio32;
  logic        f2h_write;

  modport master (
    output h2f_pio32,
    output h2f_write,
    input  f2h_pio32,
    input  f2h_write
  );

  modport slave (
    input  h2f_pio32,
    input  h2f_write,
    output f2h_pio32,
    output f2h_write
  );

endinterface

// File: rtl/f2h_event_fifo.sv
// rtl/f2h_event_fifo.sv - event FIFO with extra-bit pointers for full/empty
// A pop frees the slot a same-cycle push needs, so push+pop when full both succeed.
module f2h_event_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/f2h_event_tx.sv
// rtl/f2h_event_tx.sv - queues done_vec completion events and sends them to the host one per ACK
// Define F2H_TIMESTAMP_EN to follow each event word with its 32-bit capture timestamp.
module f2h_event_tx
  import npu_mmio_pkg::*;
#(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] ACK_OPCODE = DEFAULT_ACK_OPCODE,
  parameter logic [7:0] CLR_OPCODE = DEFAULT_CLR_OPCODE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          done_vec,
  f2h_event_tx_if.slave        host,
  output logic                 overflow,
  output logic                 busy
);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("f2h_event_tx: FIFO_DEPTH must be a power of two in 2..64");
  end

  f2h_state_e         state;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               ack;
  logic               clr;
  logic [ENTRY_W-1:0] wdata;
  logic [ENTRY_W-1:0] head;

  assign ack  = host.h2f_write && is_cmd(host.h2f_pio32, ACK_OPCODE);
  assign clr  = host.h2f_write && is_cmd(host.h2f_pio32, CLR_OPCODE);
  assign push = (done_vec != '0);
  assign pop  = (state == ST_WAIT_ACK) && ack;
  assign busy = !empty || (state != ST_IDLE);

`ifdef F2H_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + 32'd1;
  end

  assign wdata = {ts_cnt, done_vec};
`else
  assign wdata = done_vec;
`endif

  f2h_event_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // A drop in the same cycle as a host clear still leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
    else if (clr)                  overflow <= 1'b0;
  end

  // Outputs are set on entry to a send state, so the strobe is high for exactly that state's cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      host.f2h_write <= 1'b0;
      host.f2h_pio32 <= '0;
    end else begin
      host.f2h_write <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state          <= ST_SEND;
            host.f2h_write <= 1'b1;
            host.f2h_pio32 <= head[31:0];
          end
        end
        ST_SEND: state <= ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (ack) begin
`ifdef F2H_TIMESTAMP_EN
            state          <= ST_SEND_TS;
            host.f2h_write <= 1'b1;
            host.f2h_pio32 <= head[63:32];
`else
            state          <= ST_IDLE;
`endif
          end
        end
`ifdef F2H_TIMESTAMP_EN
        ST_SEND_TS: state <= ST_WAIT_TS_ACK;
        ST_WAIT_TS_ACK: begin
          if (ack) state <= ST_IDLE;
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_f2h_event_tx.sv
// tb/tb_f2h_event_tx.sv - directed self-checking bench for f2h_event_tx
// With F2H_TIMESTAMP_EN defined only the reset and timestamp scenarios run.
module tb_f2h_event_tx;
  import npu_mmio_pkg::*;

  localparam logic [31:0] ACK = 32'hA500_0000;
  localparam logic [31:0] CLR = 32'h5A00_0000;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b1;
  logic [31:0] done_vec = '0;
  logic        overflow;
  logic        busy;

  f2h_event_tx_if host_if ();

  f2h_event_tx #(.FIFO_DEPTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .done_vec (done_vec),
    .host     (host_if),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] seen[$];
  logic [31:0] model[$];

`ifdef F2H_TIMESTAMP_EN
  logic [31:0] tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Every wait goes through here so no f2h pulse is missed.
  task automatic step();
    @(negedge clk);
    if (host_if.f2h_write) seen.push_back(host_if.f2h_pio32);
  endtask

  task automatic host_cmd(input logic [31:0] w);
    host_if.h2f_pio32 = w;
    host_if.h2f_write = 1'b1;
    step();
    host_if.h2f_write = 1'b0;
    host_if.h2f_pio32 = '0;
  endtask

  task automatic push_ev(input logic [31:0] v);
    done_vec = v;
    step();
    done_vec = '0;
  endtask

  task automatic expect_word(input string tag, input logic [31:0] exp);
    int n = 0;
    while (seen.size() == 0 && n < 12) begin
      step();
      n++;
    end
    check_eq({tag, "_seen"}, {31'd0, seen.size() != 0}, 32'd1);
    if (seen.size() != 0) check_eq(tag, seen.pop_front(), exp);
  endtask

  initial begin
    logic [31:0] exps [3];
    logic [31:0] cu_ev;
    host_if.h2f_pio32 = '0;
    host_if.h2f_write = 1'b0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_write", host_if.f2h_write, 0);
    check_eq("rst_pio", host_if.f2h_pio32, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    step();

`ifdef F2H_TIMESTAMP_EN
    begin
      logic [31:0] exp_ts;
      int          guard = 0;
      while (tb_cyc != 32'd100 && guard < 200) begin
        step();
        guard++;
      end
      exp_ts = tb_cyc;
      check_eq("ts_counter_at", exp_ts, 32'd100);
      push_ev(32'h0000_0008);
      expect_word("ts_event", 32'h0000_0008);
      step();
      host_cmd(ACK);
      expect_word("ts_stamp", exp_ts);
      check_eq("ts_busy_mid", busy, 1);
      step();
      host_cmd(ACK);
      check_eq("ts_busy_end", busy, 0);
      repeat (3) step();
      check_eq("ts_no_extra", seen.size(), 0);
    end
`else
    // single event latency and hold until ACK
    cu_ev = 32'd1 << CU_BIT;
    done_vec = cu_ev;
    step();
    done_vec = '0;
    check_eq("t1_not_yet", host_if.f2h_write, 0);
    check_eq("t1_busy_early", busy, 1);
    step();
    check_eq("t1_pulse_at_2", seen.size(), 1);
    expect_word("t1_word", 32'h2000_0000);
    step();
    check_eq("t1_one_cycle", host_if.f2h_write, 0);
    check_eq("t1_pio_hold", host_if.f2h_pio32, 32'h2000_0000);
    repeat (3) step();
    check_eq("t1_no_resend", seen.size(), 0);
    check_eq("t1_busy_wait", busy, 1);
    host_cmd(ACK);
    check_eq("t1_busy_done", busy, 0);

    // three events in order, one per ACK; foreign opcodes ignored
    exps[0] = 32'h1; exps[1] = 32'h2; exps[2] = 32'h4;
    push_ev(32'h1);
    push_ev(32'h2);
    push_ev(32'h4);
    for (int k = 0; k < 3; k++) begin
      expect_word("t2_word", exps[k]);
      host_cmd(32'hA600_00A5);
      repeat (3) step();
      check_eq("t2_wait_ack", seen.size(), 0);
      host_cmd(k == 1 ? 32'hA500_1234 : ACK);
    end
    repeat (3) step();
    check_eq("t2_busy_done", busy, 0);
    check_eq("t2_no_extra", seen.size(), 0);

    // overflow: 8 fit (head in flight), extra ones drop; set beats clear
    for (int i = 1; i <= 8; i++) push_ev(32'h100 + i);
    check_eq("t3_full_no_ovf", overflow, 0);
    push_ev(32'h109);
    check_eq("t3_ovf_set", overflow, 1);
    done_vec = 32'h10A;
    host_if.h2f_pio32 = CLR;
    host_if.h2f_write = 1'b1;
    step();
    done_vec = '0;
    host_if.h2f_write = 1'b0;
    host_if.h2f_pio32 = '0;
    check_eq("t3_set_wins", overflow, 1);
    host_cmd(CLR);
    check_eq("t3_clr", overflow, 0);
    for (int k = 0; k < 8; k++) begin
      expect_word("t3_drain", 32'h101 + k);
      step();
      host_cmd(ACK);
    end
    repeat (4) step();
    check_eq("t3_drops_gone", seen.size(), 0);
    check_eq("t3_busy_done", busy, 0);

    // push+pop while full over 20 pairs, wrapping the pointers
    for (int i = 0; i < 8; i++) begin
      push_ev(32'h200 + i);
      model.push_back(32'h200 + i);
    end
    expect_word("t4_head", model[0]);
    step();
    for (int i = 0; i < 20; i++) begin
      done_vec = 32'h300 + i;
      host_if.h2f_pio32 = ACK;
      host_if.h2f_write = 1'b1;
      step();
      done_vec = '0;
      host_if.h2f_write = 1'b0;
      host_if.h2f_pio32 = '0;
      void'(model.pop_front());
      model.push_back(32'h300 + i);
      check_eq("t4_no_drop", overflow, 0);
      expect_word("t4_wrap", model[0]);
      step();
    end
    while (model.size() != 0) begin
      host_cmd(ACK);
      void'(model.pop_front());
      if (model.size() != 0) begin
        expect_word("t4_drain", model[0]);
        step();
      end
    end
    repeat (3) step();
    check_eq("t4_busy_done", busy, 0);
    check_eq("t4_ovf_final", overflow, 0);
    check_eq("t4_no_extra", seen.size(), 0);

    // reset during WAIT_ACK abandons the word
    push_ev(32'h400);
    expect_word("t5_word", 32'h400);
    step();
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_write", host_if.f2h_write, 0);
    check_eq("t5_rst_pio", host_if.f2h_pio32, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_ovf", overflow, 0);
    step();
    rst_n = 1'b1;
    step();
    host_cmd(ACK);
    repeat (4) step();
    check_eq("t5_no_retx", seen.size(), 0);
    check_eq("t5_busy_after", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/f2h_event_tx.md
F2H_EVENT_TX -- requirements
Module: f2h_event_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO entries; power of two, range 2..64.
REQ-002 Parameter ACK_OPCODE, default 8'hA5, h2f_pio32[31:24] value that acknowledges one transmitted word.
REQ-003 Parameter CLR_OPCODE, default 8'h5A, h2f_pio32[31:24] value that clears the overflow flag.
REQ-004 clk  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 done_vec  input  32  completion pulses: [27:0] exec_done, [28] fetch_done, [29] cu_done, [30] ldst_done, [31] move_done.
REQ-007 h2f_pio32  input  32  host-to-fabric MMIO word.
REQ-008 h2f_write  input  1  single-cycle strobe qualifying h2f_pio32.
REQ-009 f2h_pio32  output  32  fabric-to-host MMIO word.
REQ-010 f2h_write  output  1  single-cycle strobe qualifying f2h_pio32.
REQ-011 overflow  output  1  sticky flag: at least one event was dropped.
REQ-012 busy  output  1  high when the FIFO is not empty or the FSM is not IDLE.

Function
REQ-013 A cycle with done_vec != 0 pushes one event word equal to done_vec; done_vec == 0 pushes nothing.
REQ-014 Push when full without a same-cycle pop: event dropped, overflow set; FIFO contents unchanged.
REQ-015 Push and pop in the same cycle when full: both succeed, overflow unchanged.
REQ-016 FSM states: IDLE, SEND, WAIT_ACK, plus SEND_TS and WAIT_TS_ACK when timestamps are compiled in.
REQ-017 IDLE -> SEND when the FIFO is not empty.
REQ-018 SEND: f2h_pio32 = head event word and f2h_write = 1 for exactly one cycle; next state WAIT_ACK.
REQ-019 WAIT_ACK: on h2f_write with h2f_pio32[31:24] == ACK_OPCODE, pop the head; next state IDLE, or SEND_TS when timestamps are enabled.
REQ-020 Acks received in any state other than WAIT_ACK or WAIT_TS_ACK are ignored; non-matching h2f words are ignored.
REQ-021 On h2f_write with h2f_pio32[31:24] == CLR_OPCODE, overflow clears in any state. If a drop occurs in the same cycle, set wins.
REQ-022 Latency: a nonzero done_vec sampled at edge N with an empty FIFO and the FSM in IDLE gives f2h_write high in the cycle after edge N+1.
REQ-023 f2h_pio32 holds its last driven value when f2h_write is 0.
REQ-024 The FIFO read and write pointers wrap modulo FIFO_DEPTH; full and empty are distinguished with an extra pointer bit.

Reset
REQ-025 rst_n low asynchronously forces: FSM IDLE, FIFO empty, f2h_write 0, f2h_pio32 0, overflow 0, busy 0, timestamp counter 0.
REQ-026 Reset during SEND or WAIT_ACK abandons the in-flight word; no retransmission occurs after reset.

Configuration
REQ-027 Macro F2H_TIMESTAMP_EN defined:
  - a 32-bit free-running cycle counter (wraps 0xFFFFFFFF -> 0) is captured with each pushed event;
  - the FIFO entry is 64 bits wide;
  - SEND_TS sends the timestamp for one cycle with f2h_write = 1;
  - WAIT_TS_ACK pops nothing; its ACK returns the FSM to IDLE.
REQ-028 Macro F2H_TIMESTAMP_EN undefined: no counter, 32-bit FIFO entries, SEND_TS and WAIT_TS_ACK do not exist.

Structure
REQ-029 Shared package npu_mmio_pkg holds:
  - the FSM state enum;
  - default ACK_OPCODE and CLR_OPCODE localparams;
  - done_vec bit-index localparams (EXEC_LSB=0, FETCH=28, CU=29, LDST=30, MOVE=31).
REQ-030 The storage is one sub-module, f2h_event_fifo: parameterised width and depth, synchronous push/pop, full/empty flags, asynchronous active-low reset.

Verification
REQ-031 done_vec = 32'h2000_0000 for one cycle -> f2h_pio32 = 32'h2000_0000 with one f2h_write pulse 2 cycles later; busy stays high until ACK 0xA5000000.
REQ-032 Three consecutive events 0x1, 0x2, 0x4 with ACK after each word -> words sent in order 0x1, 0x2, 0x4; no word is sent before the previous ACK.
REQ-033 Ten events with FIFO_DEPTH=8 and no ACK -> 8 queued, 1 in flight counted among them, overflow = 1; CLR 0x5A000000 -> overflow = 0.
REQ-034 Event pushed in the same cycle as an ACK while full -> no drop, overflow stays 0; FIFO wraps correctly over 20 push/pop pairs.
REQ-035 rst_n pulsed low during WAIT_ACK -> outputs at reset values immediately; stray ACK afterwards does not generate f2h_write.
REQ-036 With F2H_TIMESTAMP_EN: event at counter 100 -> event word, then after ACK the timestamp word 100 (or the captured value) -> second ACK returns the FSM to IDLE.
